// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the five-stage DLX core: load-use stalls,
// mult/div occupancy of EX, branch flushes and a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             id_md_start,
  input  logic             branch_taken,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_enable,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [7:0]       MD_INIT = 8'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_next;
  logic [7:0] md_cnt, md_cnt_next;
  logic       load_haz;

  // Issue cycle loads md_cnt with MD_LATENCY-1; the wait ends after the cycle it reads 1.
  always_comb begin
    load_haz = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    state_next   = state;
    md_cnt_next  = md_cnt;
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    id_ex_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    md_busy      = 1'b0;
    if (reset) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_enable = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_next   = RUN;
      md_cnt_next  = 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (load_haz) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_md_start) begin
            state_next  = MD_WAIT;
            md_cnt_next = MD_INIT;
          end else if (branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_enable = 1'b0;
          md_busy      = 1'b1;
          md_cnt_next  = md_cnt - 8'd1;
          if (md_cnt == 8'd1) state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= RUN;
      md_cnt <= 8'd0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // Counts frozen-PC cycles, holding at all-ones rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!pc_enable && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a driver pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_stall_ctrl;

  localparam int MD_LAT = 8;
  localparam int CW     = 4;
  localparam int CMAX   = (1 << CW) - 1;

  typedef struct {
    bit pc_en;
    bit ifid_en;
    bit flush;
    bit idex_en;
    bit bubble;
    bit busy;
    int count;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic          id_md_start = 1'b0, branch_taken = 1'b0;
  logic          pc_enable, if_id_enable, if_id_flush;
  logic          id_ex_enable, id_ex_bubble, md_busy;
  logic [CW-1:0] stall_count;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   freeze_left = 0;
  int   model_count = 0;

  hazard_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .id_md_start(id_md_start), .branch_taken(branch_taken),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .id_ex_enable(id_ex_enable), .id_ex_bubble(id_ex_bubble), .md_busy(md_busy),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Drive one cycle of inputs, predict the outputs, then advance the model past the edge.
  task automatic applyStimulus(input bit rst, input int rs, input int rt, input bit uses_rt,
                               input bit mem_rd, input int lrt, input bit md, input bit br);
    exp_t e;
    bit   haz;
    @(posedge clock);
    #1;
    reset = rst; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses_rt;
    ex_mem_read = mem_rd; ex_rt = 5'(lrt); id_md_start = md; branch_taken = br;
    haz = mem_rd && (lrt != 0) && ((lrt == rs) || (uses_rt && lrt == rt));
    e = '{1, 1, 0, 1, 0, 0, model_count};
    if (rst) begin
      e.pc_en = 0; e.ifid_en = 0; e.idex_en = 0; e.flush = 1; e.bubble = 1;
    end else if (freeze_left > 0) begin
      e.pc_en = 0; e.ifid_en = 0; e.idex_en = 0; e.busy = 1;
    end else if (haz) begin
      e.pc_en = 0; e.ifid_en = 0; e.bubble = 1;
    end else if (!md && br) begin
      e.flush = 1;
    end
    exp_q.push_back(e);
    if (rst) begin
      model_count = 0;
      freeze_left = 0;
    end else begin
      if (!e.pc_en && model_count < CMAX) model_count++;
      if (freeze_left > 0) freeze_left--;
      else if (md && !haz) freeze_left = MD_LAT - 1;
    end
  endtask

  // Monitor: outputs are valid every cycle, so pop one prediction per negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc_enable",    int'(pc_enable),    int'(e.pc_en));
        checkOutput("if_id_enable", int'(if_id_enable), int'(e.ifid_en));
        checkOutput("if_id_flush",  int'(if_id_flush),  int'(e.flush));
        checkOutput("id_ex_enable", int'(id_ex_enable), int'(e.idex_en));
        checkOutput("id_ex_bubble", int'(id_ex_bubble), int'(e.bubble));
        checkOutput("md_busy",      int'(md_busy),      int'(e.busy));
        checkOutput("stall_count",  int'(stall_count),  e.count);
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs, then clear
    applyStimulus(0, 5, 0, 0, 1, 5, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 5, 0, 0);
    // rt-only hazard with and without id_uses_rt; $0 never hazards
    applyStimulus(0, 1, 7, 1, 1, 7, 0, 0);
    applyStimulus(0, 1, 7, 0, 1, 7, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    // Mult/div issue, freeze with inputs that must be ignored, then back to back
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MD_LAT - 1; i++) applyStimulus(0, 3, 3, 1, 1, 3, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < MD_LAT - 1; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    // Priority: hazard beats branch and md_start, then branch alone flushes
    applyStimulus(0, 4, 0, 0, 1, 4, 1, 1);
    applyStimulus(0, 4, 0, 0, 0, 4, 0, 1);
    // Reset on the third wait cycle
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    // Saturation of the counter under a held load hazard
    for (int i = 0; i < 20; i++) applyStimulus(0, 9, 0, 0, 1, 9, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic over a small register range so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 79) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom), ($urandom_range(0, 2) != 0), $urandom_range(0, 3),
                    ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
    end
    repeat (2) @(negedge clock);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
